// File: rtl/dense_layer_engine.sv
// Fully-connected layer engine: streams LANES-wide input/weight chunks,
// accumulates bias + dot product, then rounds, saturates, ReLUs and pools.
module dense_layer_engine #(
  parameter int WIDTH       = 16,
  parameter int FRAC        = 8,
  parameter int LANES       = 4,
  parameter int IN_LEN      = 8,
  parameter int OUT_NEURONS = 2,
  parameter int POOL_K      = 1,
  parameter int RELU        = 0,
  parameter int AW          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   in_rd_o,
  output logic [AW-1:0]          in_addr_o,
  input  logic [LANES*WIDTH-1:0] in_data_i,
  output logic                   w_rd_o,
  output logic [AW-1:0]          w_addr_o,
  input  logic [LANES*WIDTH-1:0] w_data_i,
  output logic [AW-1:0]          b_addr_o,
  input  logic [WIDTH-1:0]       b_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [AW-1:0]          out_addr_o,
  output logic [WIDTH-1:0]       out_data_o
);

  localparam int CHUNKS = (IN_LEN + LANES - 1) / LANES;
  localparam int ACCW   = 2*WIDTH + $clog2(IN_LEN) + 1;

  localparam logic [AW-1:0] CH_A   = AW'(CHUNKS);
  localparam logic [AW-1:0] LAST_K = AW'(CHUNKS - 1);
  localparam logic [AW-1:0] LAST_N = AW'(OUT_NEURONS - 1);
  localparam logic [AW-1:0] LAST_P = AW'(POOL_K - 1);

  localparam logic signed [ACCW-1:0] MAXV =
    {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV =
    {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_FINAL, S_RESOLVE, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] p_q, p_d;
  logic [AW-1:0] g_q, g_d;
  logic [AW-1:0] kd_q;
  logic          rd_q;

  logic signed [ACCW-1:0]    acc_q, acc_d;
  logic signed [ACCW-1:0]    lane_sum, bias_ext, sh;
  logic signed [WIDTH-1:0]   xa, wa, res;
  logic signed [WIDTH-1:0]   pool_q, pool_d;
  logic signed [2*WIDTH-1:0] prod;

  // Sum of lane products for the chunk arriving this cycle, tail lanes masked.
  always_comb begin
    lane_sum = '0;
    xa       = '0;
    wa       = '0;
    prod     = '0;
    for (int l = 0; l < LANES; l++) begin
      xa   = $signed(in_data_i[l*WIDTH +: WIDTH]);
      wa   = $signed(w_data_i[l*WIDTH +: WIDTH]);
      prod = xa * wa;
      if ((int'(kd_q) * LANES + l) < IN_LEN) begin
        lane_sum = lane_sum +
          {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
      end
    end
  end

  // Accumulator: chunk 0 reloads with the scaled bias, later chunks add.
  always_comb begin
    bias_ext = {{(ACCW-WIDTH){b_data_i[WIDTH-1]}}, b_data_i};
    acc_d    = acc_q;
    if (rd_q) begin
      acc_d = ((kd_q == '0) ? (bias_ext <<< FRAC) : acc_q) + lane_sum;
    end
  end

  // Shift back to FRAC scale, saturate to WIDTH, optional ReLU.
  always_comb begin
    sh = acc_q >>> FRAC;
    if (sh > MAXV) begin
      res = MAXV[WIDTH-1:0];
    end else if (sh < MINV) begin
      res = MINV[WIDTH-1:0];
    end else begin
      res = sh[WIDTH-1:0];
    end
    if (RELU != 0 && res[WIDTH-1]) begin
      res = '0;
    end
  end

  // Sequencing of issue, resolve, pooling and the output handshake.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    p_d     = p_q;
    g_d     = g_q;
    pool_d  = pool_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          k_d     = '0;
          n_d     = '0;
          p_d     = '0;
          g_d     = '0;
        end
      end
      S_ISSUE: begin
        k_d = k_q + 1'b1;
        if (k_q == LAST_K) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (p_q == '0 || res > pool_q) begin
          pool_d = res;
        end
        k_d = '0;
        if (p_q == LAST_P) begin
          p_d     = '0;
          state_d = S_WRITE;
        end else begin
          p_d     = p_q + 1'b1;
          n_d     = n_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_WRITE: begin
        if (out_ready_i) begin
          g_d = g_q + 1'b1;
          if (n_q == LAST_N) begin
            state_d = S_DONE;
          end else begin
            n_d     = n_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, datapath registers; synchronous reset clears all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      p_q     <= '0;
      g_q     <= '0;
      kd_q    <= '0;
      rd_q    <= 1'b0;
      acc_q   <= '0;
      pool_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      p_q     <= p_d;
      g_q     <= g_d;
      kd_q    <= k_q;
      rd_q    <= (state_q == S_ISSUE);
      acc_q   <= acc_d;
      pool_q  <= pool_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign in_rd_o     = (state_q == S_ISSUE);
  assign w_rd_o      = (state_q == S_ISSUE);
  assign in_addr_o   = k_q;
  assign w_addr_o    = n_q * CH_A + k_q;
  assign b_addr_o    = n_q;
  assign out_valid_o = (state_q == S_WRITE);
  assign out_addr_o  = g_q;
  assign out_data_o  = pool_q;

endmodule

// File: tb/tb_dense_layer_engine.sv
// Bench for dense_layer_engine: three configurations run side by side,
// expected writes queued per instance and compared at each handshake.
module tb_dense_layer_engine;

  localparam int NI = 3;
  localparam int P_IN[NI] = '{8, 6, 8};
  localparam int P_N[NI]  = '{2, 4, 2};
  localparam int P_P[NI]  = '{1, 2, 1};
  localparam int P_R[NI]  = '{0, 0, 1};

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic rdy;

  logic [15:0] xv, wv;
  logic [15:0] bias_tab[4];

  logic [31:0] sb[NI][$];
  int          dcnt[NI];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : G
    logic        busy, done, in_rd, w_rd, ov;
    logic [15:0] in_addr, w_addr, b_addr, oaddr, odata, bd;
    logic [63:0] ind, wd;

    dense_layer_engine #(
      .WIDTH(16), .FRAC(8), .LANES(4), .IN_LEN(P_IN[g]),
      .OUT_NEURONS(P_N[g]), .POOL_K(P_P[g]), .RELU(P_R[g]), .AW(16)
    ) u_dut (
      .clk(clk), .rst(rst), .start_i(start),
      .busy_o(busy), .done_o(done),
      .in_rd_o(in_rd), .in_addr_o(in_addr), .in_data_i(ind),
      .w_rd_o(w_rd), .w_addr_o(w_addr), .w_data_i(wd),
      .b_addr_o(b_addr), .b_data_i(bd),
      .out_valid_o(ov), .out_ready_i(rdy),
      .out_addr_o(oaddr), .out_data_o(odata)
    );

    // memories: 1-cycle latency, lanes past IN_LEN hold junk
    always @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
        if (in_rd)
          ind[l*16 +: 16] <= (int'(in_addr)*4 + l < P_IN[g]) ? xv : 16'h7FFF;
        if (w_rd)
          wd[l*16 +: 16] <= (int'(in_addr)*4 + l < P_IN[g]) ? wv : 16'h7FFF;
      end
      if (w_rd) bd <= bias_tab[b_addr[1:0]];
    end

    always @(negedge clk) begin
      if (!rst) begin
        if (done) dcnt[g]++;
        if (ov && rdy) begin
          if (sb[g].size() == 0)
            chk($sformatf("G%0d extra write", g), 32'(sb[g].size()), 1);
          else
            chk($sformatf("G%0d write", g), {oaddr, odata},
                sb[g].pop_front());
        end
      end
    end
  end

  function automatic logic [15:0] model(int g, int n);
    longint acc, r;
    acc = longint'($signed(bias_tab[n])) * 256 +
          longint'(P_IN[g]) * longint'($signed(xv)) * longint'($signed(wv));
    r = acc >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (P_R[g] != 0 && r < 0) r = 0;
    return r[15:0];
  endfunction

  task automatic push_exp(input int g);
    logic signed [15:0] best, v;
    for (int grp = 0; grp < P_N[g] / P_P[g]; grp++) begin
      best = model(g, grp * P_P[g]);
      for (int j = 1; j < P_P[g]; j++) begin
        v = model(g, grp * P_P[g] + j);
        if (v > best) best = v;
      end
      sb[g].push_back({16'(grp), best});
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input logic [15:0] x, w, b0, b1, b2, b3);
    xv = x;
    wv = w;
    bias_tab[0] = b0;
    bias_tab[1] = b1;
    bias_tab[2] = b2;
    bias_tab[3] = b3;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ctl"}, {27'd0, G[0].busy, G[0].done, G[0].in_rd,
                        G[0].w_rd, G[0].ov}, 0);
    chk({tag, " rd addr"}, {G[0].in_addr, G[0].w_addr}, 0);
    chk({tag, " baddr"}, {16'd0, G[0].b_addr}, 0);
    chk({tag, " out"}, {G[0].oaddr, G[0].odata}, 0);
  endtask

  task automatic run(input string tag, input int stall, input int xs);
    logic [31:0] snap;
    for (int g = 0; g < NI; g++) begin
      push_exp(g);
      dcnt[g] = 0;
    end
    rdy   = (stall == 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, " busy"}, {31'd0, G[0].busy}, 1);
    if (xs != 0) begin
      repeat (6) tick;
      start = 1'b1;
      tick;
      start = 1'b0;
    end
    if (stall != 0) begin
      for (int c = 0; c < 50 && !G[0].ov; c++) tick;
      chk({tag, " stall valid"}, {31'd0, G[0].ov}, 1);
      snap = {G[0].oaddr, G[0].odata};
      for (int c = 0; c < 5; c++) begin
        tick;
        chk({tag, " stall hold"}, {G[0].oaddr, G[0].odata}, snap);
        chk({tag, " stall ctl"}, {29'd0, G[0].ov, G[0].in_rd, G[0].w_rd},
            32'd4);
      end
      rdy = 1'b1;
    end
    for (int c = 0; c < 600 && !(dcnt[0] > 0 && dcnt[1] > 0 && dcnt[2] > 0);
         c++) tick;
    repeat (4) tick;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s G%0d done", tag, g), 32'(dcnt[g]), 1);
      chk($sformatf("%s G%0d left", tag, g), 32'(sb[g].size()), 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    rdy   = 1'b1;
    setv(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) tick;
    rst = 1'b0;
    check_zero("reset");

    setv(16'h0100, 16'h0080, 16'h0040, 16'h0040, 16'h0040, 16'h0040);
    run("basic", 0, 0);
    setv(16'h0100, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0);
    run("mask", 0, 0);
    setv(16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0);
    run("satpos", 0, 0);
    setv(16'h7FFF, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0);
    run("satneg", 0, 0);
    setv(16'h0, 16'h0, 16'h0100, 16'h0300, 16'hFF00, 16'hFE00);
    run("pool", 0, 0);
    setv(16'h0100, 16'h0080, 16'h0040, 16'h0040, 16'h0040, 16'h0040);
    run("stall", 1, 0);
    run("busystart", 0, 1);

    for (int g = 0; g < NI; g++) begin
      push_exp(g);
      dcnt[g] = 0;
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 100 && !(G[0].w_rd && G[0].w_addr == 16'd2); c++)
      tick;
    chk("abort point", {16'd0, G[0].w_addr}, 2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_zero("abort");
    for (int g = 0; g < NI; g++) sb[g].delete();
    repeat (6) tick;
    chk("abort idle", {31'd0, G[0].busy}, 0);
    run("restart", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/dense_layer_engine.md
Name: dense_layer_engine

Overview:
Parametrised fully-connected layer engine, successor to the fixed-size dense/conv layer controllers. Streams LANES-wide input-vector and weight chunks from external single-port ROM/RAM and computes y[n] = sat(bias[n] + sum x[i]*w[n][i]) in signed fixed point with an internal LANES-wide MAC. It supports optional ReLU and max-pooling over POOL_K consecutive neurons, and writes results to the next layer's buffer through a valid/ready port with backpressure.

Parameters:
WIDTH, 16, signed data/weight/bias word width
FRAC, 8, fractional bits of all operands and results
LANES, 4, words per memory read (parallel multipliers)
IN_LEN, 8, inputs per neuron (>=1; need not be a multiple of LANES)
OUT_NEURONS, 2, number of neurons (must be a multiple of POOL_K)
POOL_K, 1, max-pool group size (1 = no pooling)
RELU, 0, 1 = clamp negative results to 0 before pooling
AW, 16, address width of all memory ports

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start_i  in  1  begin layer; sampled in IDLE only
busy_o  out  1  high from the cycle after start until done
done_o  out  1  one-cycle pulse after final output handshake
in_rd_o  out  1  input-vector read strobe
in_addr_o  out  AW  chunk index k
in_data_i  in  LANES*WIDTH  chunk data, valid 1 cycle after in_rd_o; lane 0 = LSBs
w_rd_o  out  1  weight read strobe
w_addr_o  out  AW  n*CHUNKS+k
w_data_i  in  LANES*WIDTH  weight chunk, 1-cycle latency
b_addr_o  out  AW  neuron index n
b_data_i  in  WIDTH  bias, valid 1 cycle after first chunk read of neuron
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts
out_addr_o  out  AW  n/POOL_K
out_data_o  out  WIDTH  result

Behaviour:
- CHUNKS = ceil(IN_LEN/LANES). Lanes with index k*LANES+l >= IN_LEN contribute 0, whatever the data.
- Reset: all outputs 0; FSM to IDLE; counters, accumulator and pool register cleared. Reset mid-operation aborts with no write; the next start runs from neuron 0.
- States: IDLE -> ISSUE on start_i. ISSUE: one chunk read per cycle (in_rd_o=w_rd_o=1, k=0..CHUNKS-1); the accumulator adds the lane products of the chunk whose data arrives this cycle. After the last issue -> FINAL, one cycle, accumulating the last chunk. FINAL -> RESOLVE: round, saturate, ReLU, pool. RESOLVE -> WRITE if n is the last of its pool group, else -> ISSUE for n+1. WRITE: out_valid_o=1, data/addr stable until out_ready_i=1. On handshake: if last neuron -> DONE, else -> ISSUE for n+1. DONE: done_o=1 for one cycle, busy_o=0, -> IDLE.
- Bias read is issued with chunk 0; it is added as bias<<FRAC.
- Arithmetic: products are 2*WIDTH signed; accumulator is 2*WIDTH+clog2(IN_LEN)+1 bits, so it never overflows. Result = acc >>> FRAC (arithmetic shift, truncation toward -inf), saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Pool: the first neuron of a group loads the pool register; subsequent neurons keep the signed max. With POOL_K=1 every neuron is written.
- Per-neuron latency, no stall: CHUNKS+2 cycles to RESOLVE, +1 to out_valid_o.
- Backpressure: while WRITE waits, no reads are issued and outputs hold.
- start_i while busy is ignored.
- In_rd_o/w_rd_o are low outside ISSUE.

Test Plan:
1. WIDTH=16, FRAC=8, LANES=4, IN_LEN=8, OUT_NEURONS=2. x=0x0100, w=0x0080, b=0x0040 -> two writes, addr 0/1, data 0x0440; done_o pulses once; CHUNKS=2 reads per neuron.
2. IN_LEN=6, x=w=0x0100, b=0; lanes 2,3 of chunk 1 hold 0x7FFF -> data 0x0600 (masking).
3. IN_LEN=8, x=w=0x7FFF, b=0 -> 0x7FFF. w=0x8000 -> 0x8000. Same negative case with RELU=1 -> 0x0000.
4. POOL_K=2, OUT_NEURONS=4, neuron results 0x0100, 0x0300, 0xFF00, 0xFE00 -> exactly two writes: (addr 0, 0x0300), (addr 1, 0xFF00).
5. out_ready_i held low 5 cycles on the first write -> out_valid_o, out_data_o and out_addr_o stable; in_rd_o=0 throughout; exactly one transfer; the final result matches case 1.
6. rst pulsed during ISSUE of neuron 1 -> the next cycle has all outputs 0 and no write. start_i pulsed while busy is ignored. A fresh start reproduces case 1 results exactly.
